// File: rtl/scroll_bg_display_pkg.sv
// Shared constants and the procedural background tile for the scrolling layer.
// Also carries the pixel-mux latency for this layer.
package scroll_bg_display_pkg;

  localparam int H_DISPLAY  = 640;
  localparam int V_DISPLAY  = 480;
  localparam int BG_COLOR_W = 12;
  localparam int BG_SPEED_W = 4;
  localparam int LAT_BG     = 2;

  localparam logic [11:0] KEY_COLOR_DEF = 12'h000;

  // Tile image: R=col[3:0], G=row[3:0], B=mix of upper address bits
  function automatic logic [11:0] bg_pattern(
    input logic [9:0] row,
    input logic [9:0] col
  );
    return {col[3:0], row[3:0],
            col[7:4] ^ row[7:4] ^ {col[9:8], row[9:8]}};
  endfunction

endpackage

// File: rtl/scroll_bg_display_if.sv
// Pixel-path bundle between vga_sync/controller and the background layer.
// The master drives pixel position and scroll controls; the slave returns colour.
interface scroll_bg_display_if
  import scroll_bg_display_pkg::*;
#(
  parameter int COLOR_W = BG_COLOR_W,
  parameter int SPEED_W = BG_SPEED_W
);

  logic [9:0]         x;
  logic [9:0]         y;
  logic               video_on;
  logic               refr_tick;
  logic               scroll_en;
  logic               scroll_dir;
  logic [SPEED_W-1:0] speed;
  logic [9:0]         offset;
  logic [COLOR_W-1:0] rgb;
  logic               bg_on;

  modport master (
    output x, y, video_on, refr_tick,
    output scroll_en, scroll_dir, speed,
    input  offset, rgb, bg_on
  );

  modport slave (
    input  x, y, video_on, refr_tick,
    input  scroll_en, scroll_dir, speed,
    output offset, rgb, bg_on
  );

endinterface

// File: rtl/scroll_bg_display_rom.sv
// Background image ROM: one-cycle synchronous read at {row,col}.
// Addresses outside the image return black.
module bg_image_rom
  import scroll_bg_display_pkg::*;
#(
  parameter int IMG_W   = H_DISPLAY,
  parameter int IMG_H   = V_DISPLAY,
  parameter int COLOR_W = BG_COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [9:0]         row_i,
  input  logic [9:0]         col_i,
  output logic [COLOR_W-1:0] data_o
);

  logic [COLOR_W-1:0] data_q;
  logic [COLOR_W-1:0] data_d;
  logic               in_img;

  always_comb begin
    in_img = (col_i < 10'(IMG_W)) && (row_i < 10'(IMG_H));
    data_d = '0;
    if (in_img)
      data_d = COLOR_W'(bg_pattern(row_i, col_i));
  end

  always_ff @(posedge clk) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign data_o = data_q;

endmodule

// File: rtl/scroll_bg_display.sv
// Horizontally scrolling tiled background layer, fixed 2-cycle pixel latency.
// Offset advances once per frame on refr_tick; colour keyed against KEY_COLOR.
module scroll_bg_display
  import scroll_bg_display_pkg::*;
#(
  parameter int               IMG_W     = H_DISPLAY,
  parameter int               IMG_H     = V_DISPLAY,
  parameter int               COLOR_W   = BG_COLOR_W,
  parameter logic [COLOR_W-1:0] KEY_COLOR = COLOR_W'(KEY_COLOR_DEF),
  parameter int               SPEED_W   = BG_SPEED_W
) (
  input logic                clk,
  input logic                reset,
  scroll_bg_display_if.slave bus
);

  localparam logic [10:0] IMG_W11 = 11'(IMG_W);
  localparam logic [9:0]  IMG_H10 = 10'(IMG_H);

  logic [9:0]         offset_q, offset_d;
  logic [9:0]         col_q, col_d;
  logic [9:0]         row_q, row_d;
  logic               von1_q, von2_q;
  logic [10:0]        spd11, sum_w, diff_w, colsum;
  logic [COLOR_W-1:0] rom_data;

  always_comb begin
    spd11    = 11'(bus.speed);
    sum_w    = {1'b0, offset_q} + spd11;
    diff_w   = {1'b0, offset_q} - spd11;
    offset_d = offset_q;
    if (bus.refr_tick && bus.scroll_en) begin
      unique case (1'b1)
        !bus.scroll_dir:
          offset_d = (sum_w >= IMG_W11) ?
                     10'(sum_w - IMG_W11) : sum_w[9:0];
        bus.scroll_dir:
          // borrow out of bit 10 means the offset went negative
          offset_d = diff_w[10] ?
                     10'(diff_w + IMG_W11) : diff_w[9:0];
      endcase
    end
  end

  always_comb begin
    colsum = {1'b0, bus.x} + {1'b0, offset_q};
    col_d  = (colsum >= IMG_W11) ?
             10'(colsum - IMG_W11) : colsum[9:0];
    row_d  = (bus.y >= IMG_H10) ? bus.y - IMG_H10 : bus.y;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      offset_q <= '0;
      col_q    <= '0;
      row_q    <= '0;
      von1_q   <= 1'b0;
      von2_q   <= 1'b0;
    end else begin
      offset_q <= offset_d;
      col_q    <= col_d;
      row_q    <= row_d;
      von1_q   <= bus.video_on;
      von2_q   <= von1_q;
    end
  end

  bg_image_rom #(
    .IMG_W   (IMG_W),
    .IMG_H   (IMG_H),
    .COLOR_W (COLOR_W)
  ) u_rom (
    .clk    (clk),
    .rst    (reset),
    .row_i  (row_q),
    .col_i  (col_q),
    .data_o (rom_data)
  );

  assign bus.offset = offset_q;
  assign bus.rgb    = von2_q ? rom_data : '0;
  assign bus.bg_on  = von2_q && (rom_data != KEY_COLOR);

endmodule

// File: tb/tb_scroll_bg_display.sv
// Directed bench for scroll_bg_display: offset counter, wrap, latency, keying.
module tb_scroll_bg_display;
  import scroll_bg_display_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  scroll_bg_display_if bus ();

  scroll_bg_display dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.refr_tick = 1'b1;
    step();
    bus.refr_tick = 1'b0;
  endtask

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic pix(input logic [9:0] px,
                     input logic [9:0] py,
                     input logic von);
    bus.x        = px;
    bus.y        = py;
    bus.video_on = von;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset          = 1'b1;
    bus.refr_tick  = 1'b1;
    bus.scroll_en  = 1'b1;
    bus.scroll_dir = 1'b0;
    bus.speed      = 4'd5;
    pix(10'd50, 10'd10, 1'b1);

    // reset wins over refr_tick, outputs quiet throughout
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst_offset", 32'(bus.offset), 32'd0);
      check("rst_rgb", 32'(bus.rgb), 32'h000);
      check("rst_bg_on", 32'(bus.bg_on), 32'd0);
    end
    reset         = 1'b0;
    bus.refr_tick = 1'b0;

    // x beyond image width with offset 0 wraps to col 10
    pix(10'd650, 10'd20, 1'b1);
    repeat (LAT_BG) step();
    check("xwrap_rgb", 32'(bus.rgb), 32'hA41);
    check("xwrap_bg_on", 32'(bus.bg_on), 32'd1);

    // forward scroll, speed 5: 128 ticks lands exactly on 640 -> 0
    repeat (128) tick();
    check("fwd_wrap0", 32'(bus.offset), 32'd0);
    repeat (2) tick();
    check("fwd_130", 32'(bus.offset), 32'd10);

    do_reset();
    check("reset_offset", 32'(bus.offset), 32'd0);
    bus.scroll_dir = 1'b1;
    bus.speed      = 4'd3;
    tick();
    check("rev_wrap", 32'(bus.offset), 32'd637);

    // pause holds, resume advances (and wraps forward)
    bus.scroll_en = 1'b0;
    bus.speed     = 4'd7;
    tick();
    check("paused", 32'(bus.offset), 32'd637);
    bus.scroll_en  = 1'b1;
    bus.scroll_dir = 1'b0;
    tick();
    check("resume", 32'(bus.offset), 32'd4);
    bus.speed = 4'd0;
    tick();
    check("speed0", 32'(bus.offset), 32'd4);

    do_reset();
    bus.scroll_dir = 1'b1;
    bus.speed      = 4'd8;
    repeat (5) tick();
    check("rev_600", 32'(bus.offset), 32'd600);

    // back-to-back pixels: each result appears exactly 2 clk later
    pix(10'd50, 10'd10, 1'b1);
    step();
    pix(10'd40, 10'd0, 1'b1);
    step();
    check("pA_rgb", 32'(bus.rgb), 32'hAA0);
    check("pA_bg_on", 32'(bus.bg_on), 32'd1);
    pix(10'd55, 10'd490, 1'b1);
    step();
    check("pB_key_rgb", 32'(bus.rgb), 32'h000);
    check("pB_key_bg_on", 32'(bus.bg_on), 32'd0);
    pix(10'd50, 10'd10, 1'b0);
    step();
    check("pC_ywrap_rgb", 32'(bus.rgb), 32'hFA0);
    check("pC_bg_on", 32'(bus.bg_on), 32'd1);
    pix(10'd50, 10'd10, 1'b1);
    step();
    check("pD_blank_rgb", 32'(bus.rgb), 32'h000);
    check("pD_blank_bg_on", 32'(bus.bg_on), 32'd0);
    step();
    check("pE_rgb", 32'(bus.rgb), 32'hAA0);
    check("pE_bg_on", 32'(bus.bg_on), 32'd1);

    // reset mid-stream: flush, then first valid pixel 2 clk after release
    reset = 1'b1;
    step();
    check("mid_rst_rgb", 32'(bus.rgb), 32'h000);
    check("mid_rst_bg_on", 32'(bus.bg_on), 32'd0);
    check("mid_rst_offset", 32'(bus.offset), 32'd0);
    reset = 1'b0;
    step();
    check("rel1_bg_on", 32'(bus.bg_on), 32'd0);
    step();
    check("rel2_bg_on", 32'(bus.bg_on), 32'd1);
    check("rel2_rgb", 32'(bus.rgb), 32'h2A3);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
